// File: rtl/attn_score.sv
// attn_score: scaled dot-product scores of one query against a circular key cache.
// Build option ATTN_SCORE_SAT_EN: saturate each score to DATA_WIDTH bits instead of wrapping.
module attn_score #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMBED_DIM   = 64,
  parameter int FRAC_BITS   = 14,
  parameter int SEQ_LEN     = 8,
  parameter int SCALE_SHIFT = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            flush,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0] Q_flat,
  input  logic [DATA_WIDTH*EMBED_DIM-1:0] K_flat,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH*SEQ_LEN-1:0]   scores_flat,
  output logic [SEQ_LEN-1:0]              valid_mask
);

  // state | meaning
  // IDLE  | waiting for start; flush accepted here
  // LOAD  | latch query, append key at wr_ptr
  // CALC  | one MAC per cycle across all occupied slots
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = PW + ((EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1);
  localparam int JW = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam int SW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int CW = $clog2(SEQ_LEN + 1);

  localparam logic [JW-1:0] J_LAST   = JW'(EMBED_DIM - 1);
  localparam logic [SW-1:0] PTR_LAST = SW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(SEQ_LEN);

  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0] q_q [EMBED_DIM];
  logic signed [DATA_WIDTH-1:0] q_d [EMBED_DIM];
  logic signed [DATA_WIDTH-1:0] kbuf_q [SEQ_LEN][EMBED_DIM];
  logic signed [DATA_WIDTH-1:0] kbuf_d [SEQ_LEN][EMBED_DIM];
  logic [DATA_WIDTH-1:0] scores_q [SEQ_LEN];
  logic [DATA_WIDTH-1:0] scores_d [SEQ_LEN];
  logic [SW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SEQ_LEN-1:0]    valid_q, valid_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [JW-1:0]         j_q, j_d;
  logic [SW-1:0]         slot_q, slot_d;

  logic signed [PW-1:0]  prod, prod_sh;
  logic signed [AW-1:0]  term, sum, scaled;

  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [AW-1:0] v);
`ifdef ATTN_SCORE_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    kbuf_d   = kbuf_q;
    scores_d = scores_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    j_d      = j_q;
    slot_d   = slot_q;
    prod     = '0;
    prod_sh  = '0;
    term     = '0;
    sum      = '0;
    scaled   = '0;

    case (state_q)
      IDLE: begin
        // flush lands before LOAD, so a combined flush+start runs on an empty cache
        if (flush) begin
          count_d  = '0;
          wr_ptr_d = '0;
          valid_d  = '0;
        end
        if (start) state_d = LOAD;
      end

      LOAD: begin
        for (int e = 0; e < EMBED_DIM; e++) begin
          q_d[e]              = Q_flat[e*DATA_WIDTH +: DATA_WIDTH];
          kbuf_d[wr_ptr_q][e] = K_flat[e*DATA_WIDTH +: DATA_WIDTH];
        end
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + SW'(1);
        count_d  = (count_q == CNT_FULL) ? count_q : count_q + CW'(1);
        acc_d    = '0;
        j_d      = '0;
        slot_d   = '0;
        state_d  = CALC;
      end

      CALC: begin
        prod    = PW'(q_q[j_q]) * PW'(kbuf_q[slot_q][j_q]);
        prod_sh = prod >>> FRAC_BITS;
        term    = AW'(prod_sh);
        sum     = acc_q + term;
        if (j_q == J_LAST) begin
          scaled           = sum >>> SCALE_SHIFT;
          scores_d[slot_q] = narrow(scaled);
          acc_d            = '0;
          j_d              = '0;
          if (CW'(slot_q) == count_q - CW'(1)) state_d = DONE;
          else                                 slot_d  = slot_q + SW'(1);
        end else begin
          acc_d = sum;
          j_d   = j_q + JW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_q      <= '{default: '0};
      scores_q <= '{default: '0};
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      acc_q    <= '0;
      j_q      <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      scores_q <= scores_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      j_q      <= j_d;
      slot_q   <= slot_d;
    end
  end

  // Key storage is gated by valid_mask, so it needs no reset.
  always_ff @(posedge clk) begin
    kbuf_q <= kbuf_d;
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign valid_mask = valid_q;

  for (genvar s = 0; s < SEQ_LEN; s++) begin : g_scores
    assign scores_flat[s*DATA_WIDTH +: DATA_WIDTH] = scores_q[s];
  end

endmodule

// File: tb/tb_attn_score.sv
// Directed bench for attn_score with EMBED_DIM=4, SEQ_LEN=2, SCALE_SHIFT=1.
module tb_attn_score;
  localparam int DW = 32;
  localparam int ED = 4;
  localparam int SL = 2;
  localparam int VW = DW * ED;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          flush;
  logic [VW-1:0] Q_flat;
  logic [VW-1:0] K_flat;
  logic          busy;
  logic          done;
  logic [DW*SL-1:0] scores_flat;
  logic [SL-1:0] valid_mask;

  int vectors;
  int miscompares;

  attn_score #(
    .DATA_WIDTH(DW), .EMBED_DIM(ED), .FRAC_BITS(14), .SEQ_LEN(SL), .SCALE_SHIFT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .Q_flat(Q_flat), .K_flat(K_flat), .busy(busy), .done(done),
    .scores_flat(scores_flat), .valid_mask(valid_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fill(input logic [DW-1:0] v);
    logic [VW-1:0] r;
    for (int e = 0; e < ED; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] score(input int s);
    return scores_flat[s*DW +: DW];
  endfunction

  // Runs one pass; n = posedges from the start-sampling edge to done (-1 on timeout).
  // poke > 0 raises start for one cycle after edge number poke, while busy.
  task automatic do_pass(input logic [VW-1:0] q, input logic [VW-1:0] k, input bit fl,
                         input int poke, output int n, output bit busy_ok);
    @(negedge clk);
    Q_flat = q; K_flat = k; start = 1'b1; flush = fl;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n = 1;
    if (!busy) busy_ok = 1'b0;
    while (!done && n < 200) begin
      start = (n == poke);
      @(posedge clk); #1;
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
    if (!done) n = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; Q_flat = '0; K_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, valid_mask, scores_flat} !== '0) begin
      miscompares++;
      $display("FAIL reset_in: busy=%b done=%b mask=%b scores=%h, required all 0",
               busy, done, valid_mask, scores_flat);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, valid_mask, scores_flat} !== '0) begin
      miscompares++;
      $display("FAIL reset_out: busy=%b done=%b mask=%b scores=%h, required all 0",
               busy, done, valid_mask, scores_flat);
    end
  endtask

  task automatic test_first_pass();
    int n; bit bok;
    do_pass(fill(32'd16384), fill(32'd16384), 1'b0, 0, n, bok);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL first_latency: got %0d required 6", n); end
    vectors++; if (bok !== 1'b1) begin miscompares++; $display("FAIL first_busy: got %b required 1", bok); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL first_idle: busy=%b required 0", busy); end
    vectors++; if (score(0) !== 32'd32768) begin miscompares++; $display("FAIL first_s0: got %h required %h", score(0), 32'd32768); end
    vectors++; if (score(1) !== 32'd0) begin miscompares++; $display("FAIL first_s1: got %h required 0", score(1)); end
    vectors++; if (valid_mask !== 2'b01) begin miscompares++; $display("FAIL first_mask: got %b required 01", valid_mask); end
  endtask

  // Starts in the first IDLE cycle after the previous DONE.
  task automatic test_back_to_back();
    int n; bit bok;
    do_pass(fill(32'd16384), fill(32'd32768), 1'b0, 0, n, bok);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL b2b_latency: got %0d required 10", n); end
    vectors++; if (score(0) !== 32'd32768) begin miscompares++; $display("FAIL b2b_s0: got %h required %h", score(0), 32'd32768); end
    vectors++; if (score(1) !== 32'd65536) begin miscompares++; $display("FAIL b2b_s1: got %h required %h", score(1), 32'd65536); end
    vectors++; if (valid_mask !== 2'b11) begin miscompares++; $display("FAIL b2b_mask: got %b required 11", valid_mask); end
  endtask

  task automatic test_wrap();
    int n; bit bok;
    logic [DW-1:0] neg_one, neg_two;
    neg_one = 32'hFFFF_C000;
    neg_two = 32'hFFFF_8000;
    do_pass(fill(32'd16384), fill(neg_one), 1'b0, 0, n, bok);
    vectors++; if (n !== 10) begin miscompares++; $display("FAIL wrap_latency: got %0d required 10", n); end
    vectors++; if (score(0) !== neg_two) begin miscompares++; $display("FAIL wrap_s0: got %h required %h", score(0), neg_two); end
    vectors++; if (score(1) !== 32'd65536) begin miscompares++; $display("FAIL wrap_s1: got %h required %h", score(1), 32'd65536); end
    // wr_ptr is now 1: the next append must replace slot1, leaving slot0 intact
    do_pass(fill(32'd16384), fill(32'd16384), 1'b0, 0, n, bok);
    vectors++; if (score(0) !== neg_two) begin miscompares++; $display("FAIL wrap_ptr_s0: got %h required %h", score(0), neg_two); end
    vectors++; if (score(1) !== 32'd32768) begin miscompares++; $display("FAIL wrap_ptr_s1: got %h required %h", score(1), 32'd32768); end
  endtask

  task automatic test_flush();
    int n; bit bok;
    do_pass(fill(32'd16384), fill(32'd16384), 1'b1, 0, n, bok);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL flush_latency: got %0d required 6", n); end
    vectors++; if (valid_mask !== 2'b01) begin miscompares++; $display("FAIL flush_mask: got %b required 01", valid_mask); end
    vectors++; if (score(0) !== 32'd32768) begin miscompares++; $display("FAIL flush_s0: got %h required %h", score(0), 32'd32768); end
  endtask

  task automatic test_saturation();
    int n; bit bok;
    logic [DW-1:0] exp_s;
`ifdef ATTN_SCORE_SAT_EN
    exp_s = 32'h7FFF_FFFF;
`else
    exp_s = 32'h0000_0000;
`endif
    do_pass(fill(32'h4000_0000), fill(32'h4000_0000), 1'b1, 0, n, bok);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL sat_latency: got %0d required 6", n); end
    vectors++; if (score(0) !== exp_s) begin miscompares++; $display("FAIL sat_s0: got %h required %h", score(0), exp_s); end
  endtask

  task automatic test_reset_mid_calc();
    int n; bit bok;
    do_pass(fill(32'd16384), fill(32'd16384), 1'b1, 0, n, bok);
    @(negedge clk);
    K_flat = fill(32'd32768); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b required 1", busy); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, valid_mask, scores_flat} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b done=%b mask=%b scores=%h, required all 0",
               busy, done, valid_mask, scores_flat);
    end
    @(negedge clk); rst_n = 1'b1;
    // Fresh pass with a stray start pulse during CALC that must be ignored
    do_pass(fill(32'd16384), fill(32'd16384), 1'b0, 3, n, bok);
    vectors++; if (n !== 6) begin miscompares++; $display("FAIL fresh_latency: got %0d required 6", n); end
    vectors++; if (score(0) !== 32'd32768) begin miscompares++; $display("FAIL fresh_s0: got %h required %h", score(0), 32'd32768); end
    vectors++; if (score(1) !== 32'd0) begin miscompares++; $display("FAIL fresh_s1: got %h required 0", score(1)); end
    repeat (3) begin
      @(posedge clk); #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ignore_busy: got %b required 0", busy); end
    end
    vectors++; if (valid_mask !== 2'b01) begin miscompares++; $display("FAIL ignore_mask: got %b required 01", valid_mask); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_first_pass();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_saturation();
    test_reset_mid_calc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
